// File: rtl/baud_cfg_ctrl.sv
// Sequences run-time baud-rate changes into the UART tick generator:
// drain in-flight frames, apply the new code, wait for tick re-alignment, then ack.
module baud_cfg_ctrl #(
   parameter int BAUD_W       = 17,
   parameter int DEFAULT_BAUD = 9600,
   parameter int SETTLE_TICKS = 2,
   parameter int DRAIN_TO     = 200000,
   parameter int DRAIN_W      = 18
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cfg_req,
   input  logic [BAUD_W-1:0] cfg_baud,
   output logic              cfg_ack,
   output logic              cfg_err,
   output logic              busy,
   output logic              hold,
   input  logic              tx_busy,
   input  logic              rx_busy,
   input  logic              tx_tick,
   output logic [BAUD_W-1:0] baud_rate
);

   localparam int TICK_W = $clog2(SETTLE_TICKS + 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_DRAIN  = 3'd1,
      S_APPLY  = 3'd2,
      S_SETTLE = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [BAUD_W-1:0]   baud_q, baud_d;
   logic [BAUD_W-1:0]   pend_q, pend_d;
   logic [DRAIN_W-1:0]  drain_q, drain_d;
   logic [TICK_W-1:0]   tick_q, tick_d;
   logic                ack_q, ack_d;
   logic                err_q, err_d;
   logic                hold_q, hold_d;
   logic                busy_q, busy_d;

   function automatic logic is_supported(input logic [BAUD_W-1:0] code);
      logic ok;
      case (32'(code))
         32'd4800, 32'd9600, 32'd14400, 32'd19200,
         32'd38400, 32'd57600, 32'd115200, 32'd128000: ok = 1'b1;
         default:                                      ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Next-state and registered-output computation.
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      pend_d  = pend_q;
      drain_d = drain_q;
      tick_d  = tick_q;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      hold_d  = hold_q;
      busy_d  = busy_q;
      case (state_q)
         // DONE already shows busy=0, so a request there is handled as from IDLE
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            hold_d  = 1'b0;
            busy_d  = 1'b0;
            if (cfg_req) begin
               if (!is_supported(cfg_baud)) begin
                  err_d = 1'b1;
               end else if (cfg_baud == baud_q) begin
                  ack_d = 1'b1;
               end else begin
                  pend_d  = cfg_baud;
                  drain_d = DRAIN_W'(0);
                  state_d = S_DRAIN;
                  hold_d  = 1'b1;
                  busy_d  = 1'b1;
               end
            end else begin
               pend_d = pend_q;
            end
         end
         S_DRAIN: begin
            if (!tx_busy && !rx_busy) begin
               state_d = S_APPLY;
            end else if (drain_q == DRAIN_W'(DRAIN_TO - 1)) begin
               err_d   = 1'b1;
               hold_d  = 1'b0;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               drain_d = drain_q + DRAIN_W'(1);
            end
         end
         S_APPLY: begin
            baud_d  = pend_q;
            tick_d  = TICK_W'(0);
            state_d = S_SETTLE;
         end
         S_SETTLE: begin
            if (tx_tick) begin
               if (tick_q == TICK_W'(SETTLE_TICKS - 1)) begin
                  state_d = S_DONE;
                  ack_d   = 1'b1;
                  hold_d  = 1'b0;
                  busy_d  = 1'b0;
               end else begin
                  tick_d = tick_q + TICK_W'(1);
               end
            end else begin
               tick_d = tick_q;
            end
         end
         default: begin
            state_d = S_IDLE;
            hold_d  = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
      // a request while busy is rejected without touching the change in flight
      err_d = err_d | (cfg_req & busy_q);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         baud_q  <= BAUD_W'(DEFAULT_BAUD);
         pend_q  <= BAUD_W'(DEFAULT_BAUD);
         drain_q <= DRAIN_W'(0);
         tick_q  <= TICK_W'(0);
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         hold_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         pend_q  <= pend_d;
         drain_q <= drain_d;
         tick_q  <= tick_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         hold_q  <= hold_d;
         busy_q  <= busy_d;
      end
   end

   assign cfg_ack   = ack_q;
   assign cfg_err   = err_q;
   assign busy      = busy_q;
   assign hold      = hold_q;
   assign baud_rate = baud_q;

endmodule
